logic_pipe: RTL

LOGIC_PIPE -- requirements
Module: logic_pipe

---
 rtl/logic_pipe_pkg.sv | 28 ++
 rtl/logic_pipe_stage.sv | 27 ++
 rtl/logic_pipe.sv | 77 +++++++
 3 files changed

// File: rtl/logic_pipe_pkg.sv
// Shared types for logic_pipe: mode encoding, per-lane S1 payload, and lane result function.
package logic_pipe_pkg;

  typedef enum logic {
    MODE_AND  = 1'b0,
    MODE_XOR3 = 1'b1
  } mode_e;

  typedef struct packed {
    logic or_ab;
    logic and_ab;
    logic not_c;
    logic c;
  } s1_lane_t;

  localparam int S1_LANE_W = $bits(s1_lane_t);

  // Returns {x, y} for one lane; a^b is rebuilt from the stored or/and terms.
  function automatic logic [1:0] lane_result(s1_lane_t l, mode_e m);
    logic x_b;
    logic y_b;
    x_b = l.not_c ^ l.or_ab;
    if (m == MODE_XOR3) y_b = (l.or_ab & ~l.and_ab) ^ l.c;
    else                y_b = l.or_ab & (~l.and_ab ^ l.or_ab);
    return {x_b, y_b};
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// Valid/ready register slice: holds its payload while stalled, accepts when empty or draining.
module logic_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/logic_pipe.sv
// Two-stage bitwise logic pipeline with valid/ready flow control and an accepted-transfer counter.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] acc_cnt
);

  localparam int S1_W = WIDTH * S1_LANE_W + 1;
  localparam int S2_W = 2 * WIDTH;

  s1_lane_t [WIDTH-1:0] s1_in_lanes;
  s1_lane_t [WIDTH-1:0] s1_lanes;
  logic                 s1_mode;
  logic [S1_W-1:0]      s1_in_data;
  logic [S1_W-1:0]      s1_out_data;
  logic                 s1_ready;
  logic                 s1_valid;
  logic                 s2_ready;
  logic [WIDTH-1:0]     x_next;
  logic [WIDTH-1:0]     y_next;
  logic                 accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign s1_in_lanes[i] = '{or_ab: a[i] | b[i], and_ab: a[i] & b[i], not_c: ~c[i], c: c[i]};
    assign {x_next[i], y_next[i]} = lane_result(s1_lanes[i], mode_e'(s1_mode));
  end

  assign s1_in_data            = {s1_in_lanes, mode};
  assign {s1_lanes, s1_mode}   = s1_out_data;

  // Reset gates in_ready so nothing is offered as accepted (or counted) while rst is high.
  assign in_ready = s1_ready && !rst;
  assign accept   = in_valid && in_ready;

  logic_pipe_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s1_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_out_data)
  );

  logic_pipe_stage #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   ({x_next, y_next}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({x, y})
  );

  always_ff @(posedge clk) begin
    if (rst)         acc_cnt <= '0;
    else if (accept) acc_cnt <= acc_cnt + 1'b1;
  end

endmodule
